service_desk: RTL and testbench

Clocked teller-side controller for the client ticket queue. It watches the queue's `Current_Client`, `Total_Clients` and `Full` outputs and calls the next waiting ticket. It then times the call and the service, and issues the one-cycle `Done` pulse that advances the queue. It sits between the queue and the teller's counter hardware (arrival sensor, finish button, number display).

---
 rtl/service_desk.sv | 172 +++++++++++++++++
 tb/tb_service_desk.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/service_desk.sv
// Teller-side controller: calls the next waiting ticket, times the call and the
// service, and pulses Done once per ticket so the client queue advances.
module service_desk #(
    parameter int WIDTH        = 8,
    parameter int CALL_TIMEOUT = 16,
    parameter int MIN_SERVICE  = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Current_Client,
    input  logic [WIDTH-1:0] Total_Clients,
    input  logic             Full,
    input  logic             Arrived,
    input  logic             Finished,
    output logic             Done,
    output logic [WIDTH-1:0] Call_Number,
    output logic             Calling,
    output logic             Serving,
    output logic [WIDTH-1:0] Waiting,
    output logic [WIDTH-1:0] Served_Count,
    output logic [WIDTH-1:0] No_Show_Count
);

    localparam int TMAX = (CALL_TIMEOUT > MIN_SERVICE) ? CALL_TIMEOUT : MIN_SERVICE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    CALL_LIMIT = TW'(CALL_TIMEOUT - 1);
    localparam logic [TW-1:0]    FULL_LIMIT = TW'(CALL_TIMEOUT / 2 - 1);
    localparam logic [TW-1:0]    SERVE_MIN  = TW'(MIN_SERVICE - 1);
    localparam logic [TW-1:0]    SERVE_SAT  = TW'(MIN_SERVICE);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALL     = 3'd1,
        SERVE    = 3'd2,
        RELEASE  = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    state_t           state_q,       state_d;
    logic [TW-1:0]    timer_q,       timer_d;
    logic [WIDTH-1:0] call_number_q, call_number_d;
    logic [WIDTH-1:0] waiting_q,     waiting_d;
    logic [WIDTH-1:0] served_q,      served_d;
    logic [WIDTH-1:0] no_show_q,     no_show_d;
    logic             done_q,        done_d;
    logic             calling_q,     calling_d;
    logic             serving_q,     serving_d;

    logic             client_waiting_s;
    logic [TW-1:0]    call_limit_s;

    // Queue status and the no-show limit, which halves while the queue is full
    always_comb begin
        client_waiting_s = (Current_Client != Total_Clients);
        if (Full) begin
            call_limit_s = FULL_LIMIT;
        end else begin
            call_limit_s = CALL_LIMIT;
        end
    end

    // Next-state, timer and counter logic
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        call_number_d = call_number_q;
        served_d      = served_q;
        no_show_d     = no_show_q;
        waiting_d     = Total_Clients - Current_Client;

        case (state_q)
            IDLE: begin
                if (client_waiting_s) begin
                    state_d       = CALL;
                    call_number_d = Current_Client;
                    timer_d       = {TW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CALL: begin
                // Arrival wins over a timeout landing on the same edge
                if (Arrived) begin
                    state_d = SERVE;
                    timer_d = {TW{1'b0}};
                end else if (timer_q == call_limit_s) begin
                    state_d = RELEASE;
                    timer_d = {TW{1'b0}};
                    if (no_show_q != CNT_MAX) begin
                        no_show_d = no_show_q + CNT_ONE;
                    end else begin
                        no_show_d = no_show_q;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            SERVE: begin
                if (Finished && (timer_q >= SERVE_MIN)) begin
                    state_d = RELEASE;
                    timer_d = {TW{1'b0}};
                    if (served_q != CNT_MAX) begin
                        served_d = served_q + CNT_ONE;
                    end else begin
                        served_d = served_q;
                    end
                end else if (timer_q < SERVE_SAT) begin
                    timer_d = timer_q + TIMER_ONE;
                end else begin
                    timer_d = timer_q;
                end
            end
            RELEASE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Hold until the queue has moved past the ticket just released
                if (Current_Client != call_number_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = {TW{1'b0}};
            end
        endcase

        done_d    = (state_d == RELEASE);
        calling_d = (state_d == CALL);
        serving_d = (state_d == SERVE);
    end

    // State, counters and registered output decodes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            timer_q       <= {TW{1'b0}};
            call_number_q <= {WIDTH{1'b0}};
            waiting_q     <= {WIDTH{1'b0}};
            served_q      <= {WIDTH{1'b0}};
            no_show_q     <= {WIDTH{1'b0}};
            done_q        <= 1'b0;
            calling_q     <= 1'b0;
            serving_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            call_number_q <= call_number_d;
            waiting_q     <= waiting_d;
            served_q      <= served_d;
            no_show_q     <= no_show_d;
            done_q        <= done_d;
            calling_q     <= calling_d;
            serving_q     <= serving_d;
        end
    end

    assign Done          = done_q;
    assign Calling       = calling_q;
    assign Serving       = serving_q;
    assign Call_Number   = call_number_q;
    assign Waiting       = waiting_q;
    assign Served_Count  = served_q;
    assign No_Show_Count = no_show_q;

endmodule

// File: tb/tb_service_desk.sv
// Directed self-checking bench for service_desk with hand-computed expectations.
module tb_service_desk;

    logic       Clock;
    logic       Reset;
    logic [7:0] Current_Client;
    logic [7:0] Total_Clients;
    logic       Full;
    logic       Arrived;
    logic       Finished;
    logic       Done;
    logic [7:0] Call_Number;
    logic       Calling;
    logic       Serving;
    logic [7:0] Waiting;
    logic [7:0] Served_Count;
    logic [7:0] No_Show_Count;

    int checks = 0;
    int errors = 0;

    service_desk #(
        .WIDTH(8),
        .CALL_TIMEOUT(16),
        .MIN_SERVICE(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Current_Client(Current_Client),
        .Total_Clients(Total_Clients),
        .Full(Full),
        .Arrived(Arrived),
        .Finished(Finished),
        .Done(Done),
        .Call_Number(Call_Number),
        .Calling(Calling),
        .Serving(Serving),
        .Waiting(Waiting),
        .Served_Count(Served_Count),
        .No_Show_Count(No_Show_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Advance until Done is seen or the cycle budget runs out
    task automatic wait_done(input int limit, output int n, output logic seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            if (Done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Total_Clients = 8'd5; Current_Client = 8'd5;
        Full = 1'b0; Arrived = 1'b0; Finished = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({Done, Calling, Serving} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {Done, Calling, Serving});
        end
        checks++;
        if ({Call_Number, Waiting, Served_Count, No_Show_Count} !== 32'd0) begin
            errors++; $display("FAIL reset_values: got %h expected 0",
                {Call_Number, Waiting, Served_Count, No_Show_Count});
        end
        tick();
        checks++;
        if (Calling !== 1'b0) begin
            errors++; $display("FAIL idle_hold: Calling got %b expected 0", Calling);
        end
        Total_Clients = 8'd6;
        tick();
        checks++;
        if (Waiting !== 8'd1 || Calling !== 1'b1 || Call_Number !== 8'd5) begin
            errors++; $display("FAIL first_call: Waiting=%0d Calling=%b Call_Number=%0d expected 1 1 5",
                Waiting, Calling, Call_Number);
        end
    endtask

    task automatic test_serve();
        int   n;
        logic seen;
        tick(); tick();
        checks++;
        if (Calling !== 1'b1 || Serving !== 1'b0) begin
            errors++; $display("FAIL still_calling: Calling=%b Serving=%b expected 1 0", Calling, Serving);
        end
        Arrived = 1'b1; Finished = 1'b1;
        tick();
        Arrived = 1'b0;
        checks++;
        if (Serving !== 1'b1 || Calling !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL serve_entry: Serving=%b Calling=%b Done=%b expected 1 0 0",
                Serving, Calling, Done);
        end
        wait_done(20, n, seen);
        checks++;
        if (!seen || n !== 4) begin
            errors++; $display("FAIL serve_length: Done after %0d cycles (seen=%b) expected 4", n, seen);
        end
        checks++;
        if (Serving !== 1'b0 || Served_Count !== 8'd1) begin
            errors++; $display("FAIL serve_release: Serving=%b Served_Count=%0d expected 0 1",
                Serving, Served_Count);
        end
        Finished = 1'b0;
        Current_Client = 8'd6;
        tick();
        checks++;
        if (Done !== 1'b0) begin
            errors++; $display("FAIL done_single: Done got %b expected 0", Done);
        end
        tick(); tick();
        checks++;
        if (Calling !== 1'b0 || Serving !== 1'b0 || Waiting !== 8'd0) begin
            errors++; $display("FAIL back_idle: Calling=%b Serving=%b Waiting=%0d expected 0 0 0",
                Calling, Serving, Waiting);
        end
    endtask

    task automatic test_no_show();
        int   n;
        logic seen;
        Total_Clients = 8'd7;
        tick();
        checks++;
        if (Calling !== 1'b1 || Call_Number !== 8'd6) begin
            errors++; $display("FAIL ns_call: Calling=%b Call_Number=%0d expected 1 6", Calling, Call_Number);
        end
        wait_done(40, n, seen);
        checks++;
        if (!seen || n !== 16 || No_Show_Count !== 8'd1) begin
            errors++; $display("FAIL no_show: cycles=%0d seen=%b No_Show_Count=%0d expected 16 1 1",
                n, seen, No_Show_Count);
        end
        Current_Client = 8'd7;
        tick(); tick();
        Total_Clients = 8'd8; Full = 1'b1;
        tick();
        wait_done(40, n, seen);
        checks++;
        if (!seen || n !== 8 || No_Show_Count !== 8'd2 || Served_Count !== 8'd1) begin
            errors++; $display("FAIL no_show_full: cycles=%0d seen=%b No_Show=%0d Served=%0d expected 8 1 2 1",
                n, seen, No_Show_Count, Served_Count);
        end
        Full = 1'b0;
        Current_Client = 8'd8;
        tick(); tick();
    endtask

    task automatic test_wrap_ack();
        int   n;
        int   extra_done;
        logic seen;
        Current_Client = 8'd255; Total_Clients = 8'd1;
        tick();
        checks++;
        if (Waiting !== 8'd2 || Call_Number !== 8'd255 || Calling !== 1'b1) begin
            errors++; $display("FAIL wrap_call: Waiting=%0d Call_Number=%0d Calling=%b expected 2 255 1",
                Waiting, Call_Number, Calling);
        end
        Arrived = 1'b1; Finished = 1'b1;
        tick();
        Arrived = 1'b0;
        wait_done(20, n, seen);
        checks++;
        if (!seen || n !== 4) begin
            errors++; $display("FAIL wrap_serve: Done after %0d cycles (seen=%b) expected 4", n, seen);
        end
        Finished = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Done !== 1'b0 || Calling !== 1'b0) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            errors++; $display("FAIL wait_ack_hold: %0d cycles with Done/Calling got expected 0", extra_done);
        end
        Current_Client = 8'd0;
        tick();
        checks++;
        if (Calling !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL ack_idle: Calling=%b Done=%b expected 0 0", Calling, Done);
        end
        tick();
        checks++;
        if (Calling !== 1'b1 || Call_Number !== 8'd0 || Waiting !== 8'd1) begin
            errors++; $display("FAIL wrap_next: Calling=%b Call_Number=%0d Waiting=%0d expected 1 0 1",
                Calling, Call_Number, Waiting);
        end
    endtask

    task automatic test_reset_mid_serve();
        Arrived = 1'b1;
        tick();
        Arrived = 1'b0;
        tick();
        checks++;
        if (Serving !== 1'b1) begin
            errors++; $display("FAIL pre_reset_serve: Serving got %b expected 1", Serving);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({Done, Calling, Serving} !== 3'b000 ||
            {Call_Number, Waiting, Served_Count, No_Show_Count} !== 32'd0) begin
            errors++; $display("FAIL mid_reset: flags=%b values=%h expected 000 0",
                {Done, Calling, Serving}, {Call_Number, Waiting, Served_Count, No_Show_Count});
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (Calling !== 1'b1 || Call_Number !== 8'd0 || Waiting !== 8'd1 || Done !== 1'b0) begin
            errors++; $display("FAIL resume: Calling=%b Call_Number=%0d Waiting=%0d Done=%b expected 1 0 1 0",
                Calling, Call_Number, Waiting, Done);
        end
    endtask

    task automatic test_early_finish();
        int bad;
        Arrived = 1'b1;
        tick();
        Arrived = 1'b0;
        tick();
        Finished = 1'b1;
        tick();
        Finished = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Serving !== 1'b1 || Done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL early_finish: %0d cycles left SERVE got expected 0", bad);
        end
        Finished = 1'b1;
        tick();
        Finished = 1'b0;
        checks++;
        if (Done !== 1'b1 || Serving !== 1'b0 || Served_Count !== 8'd1) begin
            errors++; $display("FAIL late_finish: Done=%b Serving=%b Served=%0d expected 1 0 1",
                Done, Serving, Served_Count);
        end
        Current_Client = 8'd1;
        tick(); tick();
    endtask

    task automatic test_arrive_at_timeout();
        Total_Clients = 8'd2;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (Calling !== 1'b1 || Call_Number !== 8'd1) begin
            errors++; $display("FAIL pre_timeout: Calling=%b Call_Number=%0d expected 1 1", Calling, Call_Number);
        end
        Arrived = 1'b1;
        tick();
        Arrived = 1'b0;
        checks++;
        if (Serving !== 1'b1 || Done !== 1'b0 || No_Show_Count !== 8'd0) begin
            errors++; $display("FAIL arrive_priority: Serving=%b Done=%b No_Show=%0d expected 1 0 0",
                Serving, Done, No_Show_Count);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_no_show();
        test_wrap_ack();
        test_reset_mid_serve();
        test_early_finish();
        test_arrive_at_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
